// File: rtl/pulse_stretch_mc_if.sv
// Trigger/hold/mode inputs and stretched-output bundle for pulse_stretch_mc.
// master drives triggers and configuration; slave is the stretcher.
interface pulse_stretch_mc_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 26
);
  logic [CH-1:0]    trig_i;
  logic [CNT_W-1:0] hold_i;
  logic             mode_i;
  logic [CH-1:0]    led_o;
  logic [CH-1:0]    done_o;
  logic [CH-1:0]    busy_o;

  modport master (
    output trig_i, hold_i, mode_i,
    input  led_o, done_o, busy_o
  );

  modport slave (
    input  trig_i, hold_i, mode_i,
    output led_o, done_o, busy_o
  );
endinterface

// File: rtl/pulse_stretch_mc.sv
// Multi-channel retriggerable / one-shot pulse stretcher with synchronised triggers.
// Define PULSE_STRETCH_GUARD_EN to add a post-expiry GUARD lockout of GUARD_T cycles.
module pulse_stretch_mc #(
  parameter int unsigned      CH        = 4,
  parameter int unsigned      CNT_W     = 26,
  parameter logic [CNT_W-1:0] T_DEFAULT = 26'h2FA_F080,
  parameter bit               EDGE_TRIG = 1'b1
`ifdef PULSE_STRETCH_GUARD_EN
  ,
  parameter int unsigned      GUARD_T   = 16
`endif
) (
  input logic               clk,
  input logic               n_rst,
  pulse_stretch_mc_if.slave bus
);

`ifdef PULSE_STRETCH_GUARD_EN
  typedef enum logic [1:0] {StIdle, StActive, StGuard} state_e;
  localparam logic [CNT_W-1:0] GuardLen = CNT_W'(GUARD_T);
`else
  typedef enum logic {StIdle, StActive} state_e;
`endif

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CH-1:0]    s1_q, s2_q, s3_q;
  logic [CH-1:0]    trg;
  logic [CNT_W-1:0] hold_eff;
  state_e           state_q [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CH-1:0]    led_q, done_q, busy_q;

  always_comb begin
    trg      = EDGE_TRIG ? (s2_q & ~s3_q) : s2_q;
    hold_eff = (bus.hold_i != '0) ? bus.hold_i : T_DEFAULT;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      led_q  <= '0;
      done_q <= '0;
      busy_q <= '0;
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
      end
    end else begin
      s1_q   <= bus.trig_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      done_q <= '0;
      for (int c = 0; c < CH; c++) begin
        unique case (state_q[c])
          StIdle: begin
            if (trg[c]) begin
              state_q[c] <= StActive;
              cnt_q[c]   <= hold_eff;
              led_q[c]   <= 1'b1;
              busy_q[c]  <= 1'b1;
            end
          end
          StActive: begin
            if (trg[c] && bus.mode_i) begin
              // Reload wins over expiry so a retrigger on the last cycle leaves no gap.
              cnt_q[c] <= hold_eff;
            end else if (cnt_q[c] == CntOne) begin
              done_q[c] <= 1'b1;
              led_q[c]  <= 1'b0;
`ifdef PULSE_STRETCH_GUARD_EN
              if (GuardLen != '0) begin
                state_q[c] <= StGuard;
                cnt_q[c]   <= GuardLen;
                busy_q[c]  <= 1'b1;
              end else begin
                state_q[c] <= StIdle;
                cnt_q[c]   <= '0;
                busy_q[c]  <= 1'b0;
              end
`else
              state_q[c] <= StIdle;
              cnt_q[c]   <= '0;
              busy_q[c]  <= 1'b0;
`endif
            end else begin
              cnt_q[c] <= cnt_q[c] - CntOne;
            end
          end
`ifdef PULSE_STRETCH_GUARD_EN
          StGuard: begin
            if (cnt_q[c] == CntOne) begin
              state_q[c] <= StIdle;
              cnt_q[c]   <= '0;
              busy_q[c]  <= 1'b0;
            end else begin
              cnt_q[c] <= cnt_q[c] - CntOne;
            end
          end
`endif
          default: begin
            state_q[c] <= StIdle;
            cnt_q[c]   <= '0;
            led_q[c]   <= 1'b0;
            busy_q[c]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.led_o  = led_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Directed bench for pulse_stretch_mc: one edge-triggered and one level-triggered instance.
// History index i holds outputs sampled at the i-th falling edge after a run starts.
module tb_pulse_stretch_mc;
  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 26;
  localparam int          NS    = 48;
`ifdef PULSE_STRETCH_GUARD_EN
  localparam int          GCYC  = 4;
`else
  localparam int          GCYC  = 0;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pulse_stretch_mc_if #(.CH(CH), .CNT_W(CNT_W)) if_e ();
  pulse_stretch_mc_if #(.CH(CH), .CNT_W(CNT_W)) if_l ();

  pulse_stretch_mc #(
    .CH(CH), .CNT_W(CNT_W), .T_DEFAULT(26'd10), .EDGE_TRIG(1'b1)
`ifdef PULSE_STRETCH_GUARD_EN
    , .GUARD_T(GCYC)
`endif
  ) dut_e (.clk(clk), .n_rst(n_rst), .bus(if_e.slave));

  pulse_stretch_mc #(
    .CH(CH), .CNT_W(CNT_W), .T_DEFAULT(26'd10), .EDGE_TRIG(1'b0)
`ifdef PULSE_STRETCH_GUARD_EN
    , .GUARD_T(GCYC)
`endif
  ) dut_l (.clk(clk), .n_rst(n_rst), .bus(if_l.slave));

  int n_checks = 0;
  int n_err    = 0;

  logic [CH-1:0] stim   [NS];
  logic [CH-1:0] led_h  [NS+1];
  logic [CH-1:0] done_h [NS+1];
  logic [CH-1:0] busy_h [NS+1];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stim();
    for (int i = 0; i < NS; i++) stim[i] = '0;
  endtask

  task automatic record(input int idx, input bit lvl);
    led_h[idx]  = lvl ? if_l.led_o  : if_e.led_o;
    done_h[idx] = lvl ? if_l.done_o : if_e.done_o;
    busy_h[idx] = lvl ? if_l.busy_o : if_e.busy_o;
  endtask

  // Called at a falling edge; drives stim[i] for the next rising edge, samples at the next fall.
  task automatic run(input int n, input bit lvl);
    record(0, lvl);
    for (int i = 0; i < n; i++) begin
      if (lvl) if_l.trig_i = stim[i];
      else     if_e.trig_i = stim[i];
      @(negedge clk);
      record(i + 1, lvl);
    end
    if_e.trig_i = '0;
    if_l.trig_i = '0;
    clr_stim();
  endtask

  function automatic int n_high(input logic [CH-1:0] h [NS+1], input int ch);
    int k = 0;
    for (int i = 0; i <= NS; i++) if (h[i][ch]) k++;
    return k;
  endfunction

  function automatic int first_high(input logic [CH-1:0] h [NS+1], input int ch);
    for (int i = 0; i <= NS; i++) if (h[i][ch]) return i;
    return -1;
  endfunction

  function automatic int n_rise(input logic [CH-1:0] h [NS+1], input int ch);
    int k = 0;
    for (int i = 1; i <= NS; i++) if (h[i][ch] && !h[i-1][ch]) k++;
    return k;
  endfunction

  function automatic void clr_hist();
    for (int i = 0; i <= NS; i++) begin
      led_h[i]  = '0;
      done_h[i] = '0;
      busy_h[i] = '0;
    end
  endfunction

  initial begin
    if_e.trig_i = '0; if_e.hold_i = '0; if_e.mode_i = 1'b1;
    if_l.trig_i = '0; if_l.hold_i = '0; if_l.mode_i = 1'b1;
    clr_stim();
    clr_hist();
    #2;
    check("rst_led",  int'({if_e.led_o,  if_l.led_o}),  0);
    check("rst_done", int'({if_e.done_o, if_l.done_o}), 0);
    check("rst_busy", int'({if_e.busy_o, if_l.busy_o}), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);

    // Default hold: trigger seen at edge 1, led after edges 3..12, done after edge 13.
    stim[0] = 4'b0001;
    run(NS, 1'b0);
    check("t1_first", first_high(led_h, 0), 3);
    check("t1_len",   n_high(led_h, 0), 10);
    check("t1_rise",  n_rise(led_h, 0), 1);
    check("t1_done",  first_high(done_h, 0), 13);
    check("t1_ndone", n_high(done_h, 0), 1);
    check("t1_busy",  n_high(busy_h, 0), 10 + GCYC);
    check("t1_other", n_high(led_h, 1) + n_high(led_h, 2) + n_high(led_h, 3), 0);

    // Retrigger: 3 held cycles (cnt 6,5,4), reload, then 6 more -> 9 continuous.
    clr_hist();
    if_e.hold_i = 26'd6;
    if_e.mode_i = 1'b1;
    stim[0] = 4'b0010;
    stim[3] = 4'b0010;
    run(NS, 1'b0);
    check("t2_len",   n_high(led_h, 1), 9);
    check("t2_rise",  n_rise(led_h, 1), 1);
    check("t2_done",  first_high(done_h, 1), 12);
    check("t2_ndone", n_high(done_h, 1), 1);

    // One-shot: the second edge is lost.
    clr_hist();
    if_e.mode_i = 1'b0;
    stim[0] = 4'b0010;
    stim[3] = 4'b0010;
    run(NS, 1'b0);
    check("t3_len",   n_high(led_h, 1), 6);
    check("t3_done",  first_high(done_h, 1), 9);
    check("t3_ndone", n_high(done_h, 1), 1);

    // Retrigger on the cnt == 1 cycle (edge 7) keeps led high and suppresses done there.
    clr_hist();
    if_e.hold_i = 26'd4;
    if_e.mode_i = 1'b1;
    stim[0] = 4'b0010;
    stim[4] = 4'b0010;
    run(NS, 1'b0);
    check("t4_len",   n_high(led_h, 1), 8);
    check("t4_rise",  n_rise(led_h, 1), 1);
    check("t4_nodn7", int'(done_h[7][1]), 0);
    check("t4_done",  first_high(done_h, 1), 11);
    check("t4_ndone", n_high(done_h, 1), 1);

    // H = 1 on two channels at once.
    clr_hist();
    if_e.hold_i = 26'd1;
    stim[0] = 4'b1001;
    run(NS, 1'b0);
    check("t6_len0",  n_high(led_h, 0), 1);
    check("t6_len3",  n_high(led_h, 3), 1);
    check("t6_first", first_high(led_h, 3), 3);
    check("t6_done",  first_high(done_h, 0), 4);
    check("t6_quiet", n_high(led_h, 1), 0);

    // Level mode, 20 cycles of trigger: 20 reloads, the last followed by 4 more cycles.
    clr_hist();
    if_l.hold_i = 26'd5;
    if_l.mode_i = 1'b1;
    for (int i = 0; i < 20; i++) stim[i] = 4'b0100;
    run(NS, 1'b1);
    check("t5_first", first_high(led_h, 2), 3);
    check("t5_len",   n_high(led_h, 2), 24);
    check("t5_rise",  n_high(led_h, 2) > 0 ? n_rise(led_h, 2) : 0, 1);
    check("t5_done",  first_high(done_h, 2), 27);
    check("t5_ndone", n_high(done_h, 2), 1);

    // Reset mid-hold aborts at once with no done.
    clr_hist();
    for (int i = 0; i < NS; i++) stim[i] = 4'b0100;
    run(8, 1'b1);
    check("r_pre_led", int'(if_l.led_o[2]), 1);
    if_l.trig_i = 4'b0100;
    n_rst = 1'b0;
    #1;
    check("r_led",  int'({if_e.led_o,  if_l.led_o}),  0);
    check("r_busy", int'({if_e.busy_o, if_l.busy_o}), 0);
    check("r_done", int'({if_e.done_o, if_l.done_o}), 0);
    @(negedge clk);
    if_l.trig_i = '0;
    clr_stim();
    @(negedge clk);
    n_rst = 1'b1;
    clr_hist();
    run(20, 1'b1);
    check("r_ndone", n_high(done_h, 2), 0);
    check("r_nled",  n_high(led_h, 2), 0);

`ifdef PULSE_STRETCH_GUARD_EN
    // Hold 3 then guard 4: trigger at 4 falls in guard, trigger at 8 lands after it.
    clr_hist();
    if_e.hold_i = 26'd3;
    if_e.mode_i = 1'b1;
    stim[0] = 4'b0010;
    stim[4] = 4'b0010;
    stim[8] = 4'b0010;
    run(NS, 1'b0);
    check("g_led7",   int'(led_h[7][1]), 0);
    check("g_busy9",  int'(busy_h[9][1]), 1);
    check("g_busy10", int'(busy_h[10][1]), 0);
    check("g_led11",  int'(led_h[11][1]), 1);
    check("g_len",    n_high(led_h, 1), 6);
    check("g_nbusy",  n_high(busy_h, 1), 14);
    check("g_ndone",  n_high(done_h, 1), 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
